// File: rtl/instr_mem_fetch.sv
// Synchronous-read instruction memory with a valid/ready fetch channel and a program-load write port.
// Latency: 1 cycle from request accept to rsp_valid; sustains one fetch per cycle.
// Backpressure: holds the response while rsp_ready=0 and refuses requests until it drains; flush drops it.
module instr_mem_fetch #(
  parameter int          N          = 32,
  parameter int          MEM_SIZE   = 1024,
  parameter logic [N-1:0] FAULT_WORD = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_addr,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_fault,
  output logic [N-1:0] rsp_addr,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [N-1:0] wr_addr,
  input  logic [N-1:0] wr_data
);

  localparam int          BW       = $clog2(N / 8);
  localparam int          AW       = $clog2(MEM_SIZE);
  localparam logic [N-1:0] LOW_MASK = N'(N / 8 - 1);

  logic [N-1:0]  mem [MEM_SIZE];
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          rd_fault;
  logic          wr_fault;
  logic          accept;

  // Misaligned byte offset or any address bit above the memory span.
  function automatic logic addr_fault(input logic [N-1:0] a);
    return ((a & LOW_MASK) != '0) || ((a >> (AW + BW)) != '0);
  endfunction

  assign rd_idx   = req_addr[AW+BW-1:BW];
  assign wr_idx   = wr_addr[AW+BW-1:BW];
  assign rd_fault = addr_fault(req_addr);
  assign wr_fault = addr_fault(wr_addr);

  assign req_ready = rst & ~flush & (~rsp_valid | rsp_ready);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (wr_en && !wr_fault) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // rsp_data is the RAM read register; the nonblocking read gives old data on a same-word write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
      rsp_addr  <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= req_addr;
      rsp_fault <= rd_fault;
      rsp_data  <= rd_fault ? FAULT_WORD : mem[rd_idx];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed, table-driven bench for instr_mem_fetch plus a hand-written async-reset sequence.
module tb_instr_mem_fetch;

  localparam logic [31:0] FW = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic [31:0] rsp_addr;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  instr_mem_fetch #(.N(32), .MEM_SIZE(1024), .FAULT_WORD(FW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_fault(rsp_fault), .rsp_addr(rsp_addr),
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        rr;
    logic        fl;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_d;
    logic        e_f;
    logic [31:0] e_a;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rv, logic [31:0] ra, logic rr, logic fl,
                              logic we, logic [31:0] wa, logic [31:0] wd,
                              logic e_rdy, logic e_v, logic [31:0] e_d,
                              logic e_f, logic [31:0] e_a);
    vec_t v;
    v.rv = rv; v.ra = ra; v.rr = rr; v.fl = fl;
    v.we = we; v.wa = wa; v.wd = wd;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_d = e_d; v.e_f = e_f; v.e_a = e_a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d,
                         input logic f, input logic [31:0] a);
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v});
    chk({tag, ".rsp_data"},  rsp_data, d);
    chk({tag, ".rsp_fault"}, {31'd0, rsp_fault}, {31'd0, f});
    chk({tag, ".rsp_addr"},  rsp_addr, a);
  endtask

  initial begin
    // Columns: rv ra rr fl | we wa wd | exp: req_ready, then rsp v/data/fault/addr after the edge
    tbl.push_back(mk(0, 32'h0,    1, 0, 1, 32'h0,    32'h00500093, 1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,    1, 0, 1, 32'h4,    32'h00A00113, 1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 32'h0,    1, 0, 0, 32'h0,    32'h0,        1, 1, 32'h00500093, 0, 32'h0));
    tbl.push_back(mk(1, 32'h4,    1, 0, 0, 32'h0,    32'h0,        1, 1, 32'h00A00113, 0, 32'h4));
    tbl.push_back(mk(0, 32'h0,    1, 0, 0, 32'h0,    32'h0,        1, 0, 32'h00A00113, 0, 32'h4));
    // backpressure: held for three cycles, then drained with ready visible in the same cycle
    tbl.push_back(mk(1, 32'h4,    0, 0, 0, 32'h0,    32'h0,        1, 1, 32'h00A00113, 0, 32'h4));
    tbl.push_back(mk(1, 32'h0,    0, 0, 0, 32'h0,    32'h0,        0, 1, 32'h00A00113, 0, 32'h4));
    tbl.push_back(mk(1, 32'h0,    0, 0, 0, 32'h0,    32'h0,        0, 1, 32'h00A00113, 0, 32'h4));
    tbl.push_back(mk(1, 32'h0,    0, 0, 0, 32'h0,    32'h0,        0, 1, 32'h00A00113, 0, 32'h4));
    tbl.push_back(mk(0, 32'h0,    1, 0, 0, 32'h0,    32'h0,        1, 0, 32'h00A00113, 0, 32'h4));
    // faults, and writes that must be dropped
    tbl.push_back(mk(1, 32'h2,    1, 0, 0, 32'h0,    32'h0,        1, 1, FW,           1, 32'h2));
    tbl.push_back(mk(1, 32'h1000, 1, 0, 0, 32'h0,    32'h0,        1, 1, FW,           1, 32'h1000));
    tbl.push_back(mk(1, 32'h0,    1, 0, 1, 32'h1000, 32'hFFFFFFFF, 1, 1, 32'h00500093, 0, 32'h0));
    tbl.push_back(mk(1, 32'h0,    1, 0, 1, 32'h6,    32'hFFFFFFFF, 1, 1, 32'h00500093, 0, 32'h0));
    tbl.push_back(mk(1, 32'h4,    1, 0, 1, 32'h8,    32'h00308193, 1, 1, 32'h00A00113, 0, 32'h4));
    tbl.push_back(mk(0, 32'h0,    1, 0, 1, 32'hC,    32'h11111111, 1, 0, 32'h00A00113, 0, 32'h4));
    // flush beats a pending response and the request in the same cycle
    tbl.push_back(mk(1, 32'h8,    0, 0, 0, 32'h0,    32'h0,        1, 1, 32'h00308193, 0, 32'h8));
    tbl.push_back(mk(1, 32'hC,    0, 1, 0, 32'h0,    32'h0,        0, 0, 32'h00308193, 0, 32'h8));
    tbl.push_back(mk(1, 32'hC,    0, 0, 0, 32'h0,    32'h0,        1, 1, 32'h11111111, 0, 32'hC));
    // same-word write and fetch returns the old word; the next fetch sees the new one
    tbl.push_back(mk(1, 32'hC,    1, 0, 1, 32'hC,    32'h22222222, 1, 1, 32'h11111111, 0, 32'hC));
    tbl.push_back(mk(1, 32'hC,    1, 0, 0, 32'h0,    32'h0,        1, 1, 32'h22222222, 0, 32'hC));

    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #12;
    chk_rsp("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset.req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      req_valid = tbl[i].rv; req_addr = tbl[i].ra; rsp_ready = tbl[i].rr;
      flush = tbl[i].fl; wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      #1;
      chk($sformatf("v%0d.req_ready", i), {31'd0, req_ready}, {31'd0, tbl[i].e_rdy});
      @(posedge clk);
      #1;
      chk_rsp($sformatf("v%0d", i), tbl[i].e_v, tbl[i].e_d, tbl[i].e_f, tbl[i].e_a);
    end

    // Async reset between edges while a response is held
    req_valid = 1'b0; rsp_ready = 1'b0; wr_en = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_rsp("arst", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("arst.req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("arst.held_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    req_valid = 1'b1; req_addr = 32'hC; rsp_ready = 1'b1;
    #1;
    chk("post.req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk_rsp("post", 1'b1, 32'h22222222, 1'b0, 32'hC);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post.drain", {31'd0, rsp_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
